// File: rtl/security_pkg.sv
// Shared definitions for the intrusion alarm: FSM state encoding and default timing parameters.
package security_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_PENDING  = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  localparam int DEF_THRESH_CM  = 50;
  localparam int DEF_CONFIRM_N  = 3;
  localparam int DEF_EXIT_DLY   = 1000;
  localparam int DEF_ENTRY_DLY  = 1000;
  localparam int DEF_ALARM_LEN  = 5000;
  localparam int DEF_BLINK_HALF = 100;

  // A timed state lasting dly cycles is loaded with dly-1 and exits when the counter reads 0.
  function automatic logic [15:0] dly_load(input int dly);
    return 16'(dly - 1);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable 16-bit down-counter that stops at zero and flags it.
module alarm_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/alarm_controller.sv
// Intrusion alarm controller: arming exit delay, confirmed intrusion detection, entry delay,
// timed siren and a saturating alarm counter. All outputs are registered from the next state.
module alarm_controller
  import security_pkg::*;
#(
  parameter int THRESH_CM  = DEF_THRESH_CM,
  parameter int CONFIRM_N  = DEF_CONFIRM_N,
  parameter int EXIT_DLY   = DEF_EXIT_DLY,
  parameter int ENTRY_DLY  = DEF_ENTRY_DLY,
  parameter int ALARM_LEN  = DEF_ALARM_LEN,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Arm,
  input  logic [7:0] Distance_Raw,
  input  logic       Dist_Valid,
  output logic       Alarm,
  output logic       LED_Armed,
  output logic       LED_Alert,
  output logic [2:0] State,
  output logic [7:0] Alarm_Count
);

  localparam logic [8:0] THRESH  = 9'(THRESH_CM);
  localparam logic [3:0] CONFIRM = 4'(CONFIRM_N);

  state_t      state;
  state_t      nxt;
  logic        rst_q;
  logic [3:0]  hit_cnt;
  logic        intrusion;
  logic        clear_smp;
  logic        t_load;
  logic [15:0] t_val;
  logic        t_zero;
  logic        b_load;
  logic        b_zero;

  // Single-flop release synchroniser: assertion passes straight through, so the siren drops
  // at once, while the FSM first acts on the second edge after RST_N rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign intrusion = Dist_Valid && (Distance_Raw != 8'd0) && ({1'b0, Distance_Raw} < THRESH);
  assign clear_smp = Dist_Valid && !intrusion;

  always_comb begin
    nxt = state;
    if (!Arm) begin
      nxt = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: nxt = ST_ARMING;
        ST_ARMING:   if (t_zero) nxt = ST_ARMED;
        ST_ARMED:    if (hit_cnt == CONFIRM) nxt = ST_PENDING;
        ST_PENDING:  if (t_zero) nxt = ST_ALARM;
        ST_ALARM:    if (t_zero) nxt = ST_ARMED;
        default:     nxt = ST_DISARMED;
      endcase
    end
  end

  // The shared timer is loaded only on entry to one of the three timed states.
  always_comb begin
    t_load = 1'b0;
    t_val  = 16'd0;
    if (nxt != state) begin
      case (nxt)
        ST_ARMING:  begin t_load = 1'b1; t_val = dly_load(EXIT_DLY);  end
        ST_PENDING: begin t_load = 1'b1; t_val = dly_load(ENTRY_DLY); end
        ST_ALARM:   begin t_load = 1'b1; t_val = dly_load(ALARM_LEN); end
        default:    begin t_load = 1'b0; t_val = 16'd0;               end
      endcase
    end
  end

  assign b_load = (nxt == ST_ARMING) && ((state != ST_ARMING) || b_zero);

  alarm_timer u_state_timer (
    .clk      (CLK),
    .rst_n    (rst_q),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  alarm_timer u_blink_timer (
    .clk      (CLK),
    .rst_n    (rst_q),
    .load     (b_load),
    .load_val (dly_load(BLINK_HALF)),
    .zero     (b_zero)
  );

  always_ff @(posedge CLK or negedge rst_q) begin
    if (!rst_q) begin
      state       <= ST_DISARMED;
      hit_cnt     <= 4'd0;
      Alarm       <= 1'b0;
      LED_Armed   <= 1'b0;
      LED_Alert   <= 1'b0;
      Alarm_Count <= 8'd0;
    end else begin
      state <= nxt;

      if (state == ST_ARMED && nxt == ST_ARMED) begin
        if (intrusion && hit_cnt != CONFIRM) hit_cnt <= hit_cnt + 4'd1;
        else if (clear_smp)                  hit_cnt <= 4'd0;
      end else begin
        hit_cnt <= 4'd0;
      end

      Alarm     <= (nxt == ST_ALARM);
      LED_Alert <= (nxt == ST_PENDING) || (nxt == ST_ALARM);

      case (nxt)
        ST_DISARMED: LED_Armed <= 1'b0;
        ST_ARMING: begin
          if (state != ST_ARMING) LED_Armed <= 1'b1;
          else if (b_zero)        LED_Armed <= ~LED_Armed;
        end
        default:     LED_Armed <= 1'b1;
      endcase

      if (state == ST_PENDING && nxt == ST_ALARM && Alarm_Count != 8'hFF)
        Alarm_Count <= Alarm_Count + 8'd1;
    end
  end

  assign State = state;

endmodule
